// File: rtl/pulse_generator_p.sv
// Pulse waveform from phase accumulator; duty threshold computed by a restoring divider
// and swapped in only at phase wrap. Latency phase->square_out 1 clk; no backpressure.
module pulse_generator_p #(
  parameter int PHASE_W = 12,
  parameter int OUT_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase,
  input  logic [1:0]         duty_mode,
  input  logic [6:0]         duty_cont,
  input  logic               cont_enable,
  input  logic               enable,
  input  logic               invert,
  input  logic [OUT_W-1:0]   amp_hi,
  input  logic [OUT_W-1:0]   amp_lo,
  output logic [OUT_W-1:0]   square_out,
  output logic               cycle_start,
  output logic               busy,
  output logic [PHASE_W-1:0] thr_active
);

  localparam int DIV_W = PHASE_W + 7;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t             r_state, w_state_nxt;
  logic [9:0]         r_cfg;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIV_W-1:0]   r_dq;
  logic [6:0]         r_rem;
  logic [6:0]         r_den;
  logic [PHASE_W-1:0] r_pend_thr;
  logic               r_pend_vld;
  logic [PHASE_W-1:0] r_thr_active;
  logic [PHASE_W-1:0] r_phase_q;

  logic [6:0]         w_dc;
  logic [9:0]         w_cfg_live;
  logic               w_load;
  logic               w_last;
  logic [DIV_W-1:0]   w_num;
  logic [6:0]         w_den;
  logic [7:0]         w_rem_sh;
  logic               w_ge;
  logic [6:0]         w_rem_nxt;
  logic [DIV_W-1:0]   w_dq_nxt;
  logic               w_wrap;
  logic [PHASE_W-1:0] w_thr_eff;
  logic               w_pulse;

  // Ignored fields are pinned so they never cause a spurious recalculation.
  assign w_dc       = (duty_cont == 7'd0) ? 7'd1 : (duty_cont > 7'd99) ? 7'd99 : duty_cont;
  assign w_cfg_live = cont_enable ? {1'b1, 2'b00, w_dc} : {1'b0, duty_mode, 7'd1};

  assign w_load = (r_state == S_IDLE) && (w_cfg_live != r_cfg);
  assign w_last = (r_state == S_CALC) && (r_cnt == CNT_W'(DIV_W - 1));

  assign w_num = cont_enable ? {w_dc, {PHASE_W{1'b0}}}
                             : {6'd0, 1'b1, {PHASE_W{1'b0}}};

  always_comb begin
    w_den = 7'd100;
    if (!cont_enable) begin
      case (duty_mode)
        2'b00:   w_den = 7'd2;
        2'b01:   w_den = 7'd3;
        2'b10:   w_den = 7'd4;
        default: w_den = 7'd7;
      endcase
    end
  end

  // Remainder stays below the divisor (<=100), so 7 bits hold it between steps.
  assign w_rem_sh  = {r_rem, r_dq[DIV_W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_den});
  assign w_rem_nxt = w_ge ? 7'(w_rem_sh - {1'b0, r_den}) : w_rem_sh[6:0];
  assign w_dq_nxt  = {r_dq[DIV_W-2:0], w_ge};

  assign w_wrap    = (phase < r_phase_q);
  assign w_thr_eff = (w_wrap && r_pend_vld) ? r_pend_thr : r_thr_active;
  assign w_pulse   = (phase < w_thr_eff) ^ invert;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg        <= {1'b0, 2'b00, 7'd1};
      r_cnt        <= '0;
      r_dq         <= '0;
      r_rem        <= '0;
      r_den        <= '0;
      r_pend_thr   <= '0;
      r_pend_vld   <= 1'b0;
      r_thr_active <= {1'b1, {(PHASE_W-1){1'b0}}};
      r_phase_q    <= '0;
      square_out   <= '0;
      cycle_start  <= 1'b0;
    end else begin
      if (w_load) begin
        r_cfg <= w_cfg_live;
        r_dq  <= w_num;
        r_den <= w_den;
        r_rem <= '0;
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_dq  <= w_dq_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_phase_q   <= phase;
      cycle_start <= w_wrap;
      square_out  <= (enable && w_pulse) ? amp_hi : amp_lo;

      if (w_wrap && r_pend_vld) begin
        r_thr_active <= r_pend_thr;
        r_pend_vld   <= 1'b0;
      end
      // A result landing on a consuming wrap must survive, so this comes last.
      if (w_last) begin
        r_pend_thr <= w_dq_nxt[PHASE_W-1:0];
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign busy       = (r_state == S_CALC);
  assign thr_active = r_thr_active;

endmodule

// File: tb/tb_pulse_generator_p.sv
// Randomized bench for pulse_generator_p against a cycle-level reference model
// that computes thresholds by direct arithmetic and tracks busy as a countdown.
module tb_pulse_generator_p;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] phase;
  logic [1:0]  duty_mode;
  logic [6:0]  duty_cont;
  logic        cont_enable, enable, invert;
  logic [11:0] amp_hi, amp_lo;
  logic [11:0] square_out;
  logic        cycle_start, busy;
  logic [11:0] thr_active;

  pulse_generator_p #(.PHASE_W(12), .OUT_W(12)) dut (
    .clk(clk), .rst(rst), .phase(phase), .duty_mode(duty_mode),
    .duty_cont(duty_cont), .cont_enable(cont_enable), .enable(enable),
    .invert(invert), .amp_hi(amp_hi), .amp_lo(amp_lo),
    .square_out(square_out), .cycle_start(cycle_start), .busy(busy),
    .thr_active(thr_active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int step  = 64;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] m_sq, m_ta, m_pt, m_pq, m_thr, m_res;
  logic        m_cs, m_pv, m_wrap;
  logic [9:0]  m_cfg;
  int          m_cnt;

  function automatic logic [9:0] live_cfg();
    int dc;
    dc = (duty_cont == 0) ? 1 : (duty_cont > 99) ? 99 : int'(duty_cont);
    return cont_enable ? {1'b1, 2'b00, 7'(dc)} : {1'b0, duty_mode, 7'd1};
  endfunction

  function automatic logic [11:0] target(input logic [9:0] cfg);
    int k;
    if (cfg[9]) return 12'((int'(cfg[6:0]) * 4096) / 100);
    case (cfg[8:7])
      2'd0: k = 2;
      2'd1: k = 3;
      2'd2: k = 4;
      default: k = 7;
    endcase
    return 12'(4096 / k);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sq = 0; m_cs = 0; m_pv = 0; m_pt = 0; m_pq = 0; m_cnt = 0;
      m_ta = 12'd2048; m_cfg = {1'b0, 2'b00, 7'd1};
    end else begin
      m_wrap = (phase < m_pq);
      m_thr  = (m_wrap && m_pv) ? m_pt : m_ta;
      m_sq   = (enable && ((phase < m_thr) != invert)) ? amp_hi : amp_lo;
      m_cs   = m_wrap;
      if (m_wrap && m_pv) begin m_ta = m_pt; m_pv = 0; end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_pt = m_res; m_pv = 1; end
      end else if (live_cfg() != m_cfg) begin
        m_cfg = live_cfg();
        m_res = target(m_cfg);
        m_cnt = 19;
      end
      m_pq = phase;
    end
  end

  task automatic tick();
    @(negedge clk);
    chk("square_out",  32'(square_out),  32'(m_sq));
    chk("cycle_start", 32'(cycle_start), 32'(m_cs));
    chk("busy",        32'(busy),        32'(m_cnt > 0));
    chk("thr_active",  32'(thr_active),  32'(m_ta));
    phase = phase + 12'(step);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sq"},   32'(square_out),  32'd0);
    chk({tag, "_cs"},   32'(cycle_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy),        32'd0);
    chk({tag, "_thr"},  32'(thr_active),  32'd2048);
  endtask

  int busy_cycles;

  initial begin
    rst = 1'b1; phase = 0; duty_mode = 2'b00; duty_cont = 7'd50;
    cont_enable = 0; enable = 1; invert = 0; amp_hi = 12'hABC; amp_lo = 12'h123;
    #12;
    check_reset_vals("reset");
    @(negedge clk); rst = 1'b0;

    // Default half duty, ramp +64/clk
    run(150);
    chk("thr_half", 32'(thr_active), 32'd2048);

    // Mode 11 mid-period; busy must last exactly 19 cycles
    duty_mode = 2'b11;
    busy_cycles = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    chk("busy_len", 32'(busy_cycles), 32'd19);
    run(80);
    chk("thr_1_7", 32'(thr_active), 32'd585);

    // Continuous duty with clamping
    cont_enable = 1; duty_cont = 7'd0;
    run(100);
    chk("thr_dc0", 32'(thr_active), 32'd40);
    duty_cont = 7'd99;
    run(100);
    chk("thr_dc99", 32'(thr_active), 32'd4055);
    duty_cont = 7'd127;
    tick(); tick();
    chk("no_recalc", 32'(busy), 32'd0);
    run(100);
    chk("thr_dc127", 32'(thr_active), 32'd4055);

    // Change during CALC: last value wins
    duty_cont = 7'd50;
    run(5);
    duty_cont = 7'd25;
    run(150);
    chk("thr_dc25", 32'(thr_active), 32'd1024);

    // Reset mid-calculation
    duty_cont = 7'd60;
    run(5);
    rst = 1'b1;
    #1;
    check_reset_vals("midcalc");
    #2 rst = 1'b0;
    run(150);
    chk("thr_dc60", 32'(thr_active), 32'd2457);

    // Inverted levels, then enable off
    invert = 1; amp_hi = 12'd3000; amp_lo = 12'd100;
    run(70);
    enable = 0;
    tick();
    chk("en0_out", 32'(square_out), 32'd100);
    run(70);

    // Randomized phase steps, config and level changes
    for (int i = 0; i < 2500; i++) begin
      step = $urandom_range(1, 400);
      if ($urandom_range(0, 39) == 0) begin
        cont_enable = 1'($urandom);
        duty_mode   = 2'($urandom);
        duty_cont   = 7'($urandom);
      end
      if ($urandom_range(0, 19) == 0) begin
        enable = 1'($urandom);
        invert = 1'($urandom);
        amp_hi = 12'($urandom);
        amp_lo = 12'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
